// File: rtl/posit_shift_pkg.sv
// rtl/posit_shift_pkg.sv - shared widths, step helper and stage payload type for the posit left shifter
package posit_shift_pkg;

  localparam int DEF_N = 16;
  localparam int DEF_S = 4;

  typedef struct packed {
    logic [DEF_N-1:0] data;
    logic [DEF_S-1:0] rem_shift;
    logic             ovf;
  } shift_payload_t;

  function automatic int shift_step(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/dsl_stage.sv
// rtl/dsl_stage.sv - one shift-by-2^K stage with payload/valid register; ovf logic under DSL_LEFT_OVF_EN
module dsl_stage
  import posit_shift_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int S = DEF_S,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prev_valid,
  input  logic [N-1:0] prev_data,
  input  logic [S-1:0] prev_rem,
  input  logic         prev_ovf,
  input  logic         next_ready,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] data,
  output logic [S-1:0] rem,
  output logic         ovf
);

  localparam int STEP = shift_step(K);

  typedef struct packed {
    logic [N-1:0] data;
    logic [S-1:0] rem_shift;
  } stage_pay_t;

  stage_pay_t   pay_q;
  logic         valid_q;
  logic [N-1:0] shifted;
  logic         lost;

  // prev_rem[0] is this stage's shift bit; higher bits travel on
  if (STEP >= N) begin : g_full
    assign shifted = '0;
    assign lost    = |prev_data;
  end else begin : g_part
    assign shifted = prev_data << STEP;
    assign lost    = |prev_data[N-1 -: STEP];
  end

  assign ready = !valid_q || next_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else if (ready) begin
      valid_q         <= prev_valid;
      pay_q.data      <= prev_rem[0] ? shifted : prev_data;
      pay_q.rem_shift <= prev_rem >> 1;
    end
  end

`ifdef DSL_LEFT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ready) begin
      ovf_q <= prev_ovf | (prev_rem[0] & lost);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = prev_ovf ^ lost;
  assign ovf        = 1'b0;
`endif

  assign valid = valid_q;
  assign data  = pay_q.data;
  assign rem   = pay_q.rem_shift;

endmodule

// File: rtl/dsl_left_pipe.sv
// rtl/dsl_left_pipe.sv - pipelined dynamic left shifter c = a << b, one stage per shift bit; ovf via DSL_LEFT_OVF_EN
module dsl_left_pipe
  import posit_shift_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int S = DEF_S
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  logic [S-1:0]        stage_valid;
  logic [S-1:0]        stage_ready;
  logic [S-1:0]        stage_ovf;
  logic [S-1:0]        next_ready;
  logic [S-1:0][N-1:0] stage_data;
  logic [S-1:0][S-1:0] stage_rem;

  // Bubble-collapsing ready chain, unrolled from the output back
  always_comb begin
    logic rdy_acc;
    next_ready = '0;
    rdy_acc    = out_ready;
    for (int k = S - 1; k >= 0; k--) begin
      next_ready[k] = rdy_acc;
      rdy_acc       = !stage_valid[k] || rdy_acc;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic         pv;
    logic [N-1:0] pd;
    logic [S-1:0] pr;
    logic         po;

    if (k == 0) begin : g_first
      assign pv = in_valid;
      assign pd = a;
      assign pr = b;
      assign po = 1'b0;
    end else begin : g_next
      assign pv = stage_valid[k-1];
      assign pd = stage_data[k-1];
      assign pr = stage_rem[k-1];
      assign po = stage_ovf[k-1];
    end

    dsl_stage #(
      .N (N),
      .S (S),
      .K (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (pv),
      .prev_data  (pd),
      .prev_rem   (pr),
      .prev_ovf   (po),
      .next_ready (next_ready[k]),
      .ready      (stage_ready[k]),
      .valid      (stage_valid[k]),
      .data       (stage_data[k]),
      .rem        (stage_rem[k]),
      .ovf        (stage_ovf[k])
    );
  end

  logic unused_sink;
  assign unused_sink = ^{stage_ready, stage_rem[S-1]};

  assign in_ready  = stage_ready[0];
  assign out_valid = stage_valid[S-1];
  assign c         = stage_data[S-1];
  assign ovf       = stage_ovf[S-1];

endmodule

// File: tb/tb_dsl_left_pipe.sv
// tb/tb_dsl_left_pipe.sv - scoreboard bench for dsl_left_pipe; expected ovf follows DSL_LEFT_OVF_EN
module tb_dsl_left_pipe;
  import posit_shift_pkg::*;

  localparam int N = DEF_N;
  localparam int S = DEF_S;
`ifdef DSL_LEFT_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a = '0;
  logic [S-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] c;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  bit mon_en = 1'b0;
  shift_payload_t sb[$];
  shift_payload_t mon_exp;

  dsl_left_pipe #(.N(N), .S(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic shift_payload_t model(input logic [N-1:0] x, input logic [S-1:0] sh);
    logic [2*N-1:0] wide;
    shift_payload_t r;
    wide        = {{N{1'b0}}, x} << sh;
    r.data      = wide[N-1:0];
    r.rem_shift = '0;
    r.ovf       = OVF_ON & (|wide[2*N-1:N]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(a, b));
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output c=%h ovf=%b (queue empty)", c, ovf);
        end else begin
          mon_exp = sb.pop_front();
          if (c !== mon_exp.data || ovf !== mon_exp.ovf) begin
            failures++;
            $display("FAIL sb_result got c=%h ovf=%b want c=%h ovf=%b", c, ovf, mon_exp.data, mon_exp.ovf);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] x, input logic [S-1:0] sh, input logic rdy);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = x;
    b         = sh;
    out_ready = rdy;
    #1;
  endtask

  task automatic wait_idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (c !== 16'h0000) begin failures++; $display("FAIL reset_c got=%h want=0000", c); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_latency();
    drive(1'b1, 16'h0001, 4'd15, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      if (i == 3) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b want=0", out_valid); end
      end
      if (i == 4) begin
        checks++;
        if (out_valid !== 1'b1 || c !== 16'h8000 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL latency_result got v=%b c=%h ovf=%b want v=1 c=8000 ovf=0", out_valid, c, ovf);
        end
      end
    end
  endtask

  task automatic test_ovf();
    drive(1'b1, 16'hC001, 4'd1, 1'b1);
    wait_idle(4);
    checks++;
    if (out_valid !== 1'b1 || c !== 16'h8002 || ovf !== OVF_ON) begin
      failures++;
      $display("FAIL ovf_c001 got v=%b c=%h ovf=%b want v=1 c=8002 ovf=%b", out_valid, c, ovf, OVF_ON);
    end
  endtask

  task automatic test_boundaries();
    drive(1'b1, 16'hA5A5, 4'd0, 1'b1);
    wait_idle(4);
    checks++;
    if (c !== 16'hA5A5 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_shift got c=%h ovf=%b want c=a5a5 ovf=0", c, ovf);
    end
    drive(1'b1, 16'hFFFF, 4'd15, 1'b1);
    wait_idle(4);
    checks++;
    if (c !== 16'h8000 || ovf !== OVF_ON) begin
      failures++;
      $display("FAIL max_shift got c=%h ovf=%b want c=8000 ovf=%b", c, ovf, OVF_ON);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hist;
    hist = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) begin
        drive(1'b1, 16'($urandom), 4'(cyc), 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      end else begin
        drive(1'b0, '0, '0, 1'b1);
      end
      hist[cyc] = out_valid;
    end
    checks++;
    if (hist !== 16'h0FF0) begin failures++; $display("FAIL b2b_out_pattern got=%h want=0ff0", hist); end
  endtask

  task automatic test_fill_stall();
    int acc;
    logic [N-1:0] pend_a;
    logic [S-1:0] pend_b;
    logic [N-1:0] c_hold;
    acc    = 0;
    c_hold = '0;
    pend_a = 16'($urandom) | 16'h0001;
    pend_b = 4'($urandom_range(0, 7));
    for (int cyc = 0; cyc < 7; cyc++) begin
      drive(1'b1, pend_a, pend_b, 1'b0);
      if (cyc == 4) c_hold = c;
      if (cyc > 4) begin
        checks++;
        if (c !== c_hold) begin failures++; $display("FAIL stall_c_stable got=%h want=%h", c, c_hold); end
      end
      if (in_ready) begin
        acc++;
        pend_a = 16'($urandom) | 16'h0001;
        pend_b = 4'($urandom_range(0, 7));
      end
    end
    checks++;
    if (acc !== 4) begin failures++; $display("FAIL fill_accepts got=%0d want=4", acc); end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b1, pend_a, pend_b, 1'b1);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_flow cyc=%0d got in_ready=%b out_valid=%b want 1 1", cyc, in_ready, out_valid);
      end
      if (in_ready) begin
        pend_a = 16'($urandom);
        pend_b = 4'($urandom_range(0, 15));
      end
    end
    wait_idle(6);
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    int out_start;
    sent      = 0;
    cyc       = 0;
    out_start = n_out;
    while (sent < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    checks++;
    if (sent !== 10000) begin failures++; $display("FAIL random_sent got=%0d want=10000 (cycle budget)", sent); end
    cyc = 0;
    drive(1'b0, '0, '0, 1'b1);
    while (sb.size() != 0 && cyc < 100) begin
      drive(1'b0, '0, '0, 1'b1);
      cyc++;
    end
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL random_drain got pending=%0d want=0", sb.size()); end
    checks++;
    if (n_out - out_start !== sent) begin
      failures++;
      $display("FAIL random_count got=%0d want=%0d", n_out - out_start, sent);
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] hist;
    hist = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(cyc < 3, 16'h1234 + 16'(cyc), 4'd1, 1'b0);
    end
    checks++;
    if (out_valid !== 1'b1 || c !== 16'h2468) begin
      failures++;
      $display("FAIL midflight_pre got v=%b c=%h want v=1 c=2468", out_valid, c);
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || c !== 16'h0000 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midflight_reset got v=%b c=%h ovf=%b want v=0 c=0000 ovf=0", out_valid, c, ovf);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b1, 16'h0003, 4'd2, 1'b1);
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b0, '0, '0, 1'b1);
      hist[cyc] = out_valid;
      if (cyc == 3) begin
        checks++;
        if (c !== 16'h000C) begin failures++; $display("FAIL post_reset_c got=%h want=000c", c); end
      end
    end
    checks++;
    if (hist !== 8'h08) begin failures++; $display("FAIL post_reset_pattern got=%h want=08", hist); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ovf();
    test_boundaries();
    test_back_to_back();
    test_fill_stall();
    test_random();
    test_reset_midflight();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL final_queue got pending=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsl_left_pipe.md
Name: dsl_left_pipe

Overview:
- Pipelined dynamic left shifter: c = a << b. One register stage per shift-amount bit, with valid/ready flow control on both sides.
- Counterpart to the combinational right shifter used in posit decode. Used on the posit encode/normalize path of the PairHMM posit datapath: it left-aligns fraction/regime fields before rounding and packing.
- Sustains one operation per cycle at the clock rates used in the AFU.

Parameters:
- N, 16, data width in bits.
- S, 4, shift-amount width; shift range 0..2^S-1. Shifts of N or more yield zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- a  in  N  data to shift.
- b  in  S  left-shift amount (unsigned).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- c  out  N  shifted result; zeros fill from the LSB.
- ovf  out  1  at least one '1' bit was shifted out of the MSB. See Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear.
  - out_valid=0, c=0, ovf=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards all in-flight operands; no partial result is emitted.
- Pipeline: S stages, k=0..S-1.
  - Stage k registers data_k, the remaining shift bits b[S-1:k+1], ovf_k and v_k.
  - Stage k computes data_k = b[k] ? data_{k-1} << 2^k : data_{k-1}. Stage 0 uses a.
  - Stage widths are exactly N bits. Bits pushed past bit N-1 are dropped.
- Output mapping: c, ovf and out_valid are driven directly from stage S-1 registers. There is no combinational path from a or b to c.
- Handshake:
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - rdy_k = !v_k || rdy_{k+1}, with rdy_S = out_ready. in_ready = rdy_0.
  - This combinational ready chain is intentional: bubbles collapse, so a stalled output does not block upstream stages that hold no data.
  - A stage loads when rdy_k is 1. It sets v_k from v_{k-1} (stage 0 uses in_valid). Otherwise it holds its contents.
- Latency and throughput:
  - S cycles from input transfer to out_valid, with no stall.
  - Throughput is 1 operation per cycle with out_ready held at 1.
  - Full: when all S stages are valid and out_ready=0, in_ready=0 and every stage holds.
  - Simultaneous accept and drain when full with out_ready=1: in_ready=1 and all stages advance in the same cycle.
- Ordering: results leave strictly in input order. Nothing is dropped or duplicated under any out_ready pattern.
- Holding rules:
  - c and ovf stay stable while out_valid=1 and out_ready=0.
  - a and b are sampled only on input transfer. Upstream may change them freely when in_valid=0.
- Boundaries:
  - b=0 gives c=a and ovf=0.
  - b >= N gives c=0, with ovf=1 iff a != 0 (when ovf is enabled).

Optional Feature:
- Macro DSL_LEFT_OVF_EN.
- Defined: each stage computes ovf_k = ovf_{k-1} | (b[k] && |data_{k-1}[N-1 : N-2^k]). For 2^k >= N, the whole word is tested. ovf is registered alongside data.
- Undefined: ovf is tied to 0, no ovf flops are instantiated, and the port remains present.

Decomposition:
- Package posit_shift_pkg holds:
  - the default-width constants (N, S);
  - a function shift_step(k) returning 2^k;
  - a typedef for the stage payload record {data, rem_shift, ovf}.
- One sub-module, dsl_stage:
  - parameterized by N, S and stage index K;
  - contains one shift-by-2^K mux, its payload/valid register and its local ready equation;
  - instantiated S times via generate in dsl_left_pipe.

Test Plan:
- N=16, S=4; a=16'h0001, b=4'd15, out_ready=1 -> after 4 cycles c=16'h8000, out_valid=1, ovf=0.
- a=16'hC001, b=4'd1 -> c=16'h8002, ovf=1 with DSL_LEFT_OVF_EN defined, ovf=0 without it.
- Back-to-back stream of 8 operands, out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready constantly 1.
- Fill with out_ready=0 -> in_ready drops after 4 accepts and c holds stable. Then out_ready=1 with in_valid=1 -> one input accepted and one result drained per cycle, no loss.
- Random out_ready (50%) and random in_valid, 10k ops -> scoreboard matches (a<<b) truncated to N bits, and ovf matches the reference model.
- Assert rst_n low while 3 ops are in flight -> out_valid=0 and c=0 immediately. After release, the first new op emerges alone after 4 cycles.
